// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//   ARM instruction decode stage built around a 2-entry skid buffer. Each
//   accepted instruction is decoded on entry and stored. The outputs always
//   present the oldest held entry, and every output is driven from a flop.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-low reset
//   flush            discard all held instructions on the next edge
//   instrIn/pcIn     raw instruction word and its address
//   inValid/inReady  upstream handshake
//   outValid/outReady downstream handshake
//   opcode           shifter/ALU opcode (5'b11111 for unsupported classes)
//   immediateOperand instruction bit 25
//   data12Out        instruction bits [11:0]
//   branchOffset     instruction bits [23:0]
//   condCode         instruction bits [31:28]
//   setFlags         instruction bit 20
//   rnAddr/rdAddr/rmAddr instruction bits [19:16]/[15:12]/[3:0]
//   pcOut            address of the presented instruction
//   undefInstr       presented instruction is in an unsupported class
// ---------------------------------------------------------------------------
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcIn,
    input  logic        inValid,
    output logic        inReady,
    output logic        outValid,
    input  logic        outReady,
    output logic [4:0]  opcode,
    output logic        immediateOperand,
    output logic [11:0] data12Out,
    output logic [23:0] branchOffset,
    output logic [3:0]  condCode,
    output logic        setFlags,
    output logic [3:0]  rnAddr,
    output logic [3:0]  rdAddr,
    output logic [3:0]  rmAddr,
    output logic [31:0] pcOut,
    output logic        undefInstr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // One buffer entry, already decoded.
    typedef struct packed {
        logic [4:0]  opcode;
        logic        imm;
        logic [11:0] data12;
        logic [23:0] boff;
        logic [3:0]  cond;
        logic        setf;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [31:0] pc;
        logic        undef;
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;   // oldest entry, drives the outputs
    entry_t skid_q, skid_d;   // second entry, only meaningful in FULL
    logic   inReady_q;
    logic   outValid_q;

    entry_t dec_in;
    logic   in_xfer;
    logic   out_xfer;

    // Field extraction and class-based opcode for the incoming word.
    always_comb begin
        dec_in        = '0;
        dec_in.imm    = instrIn[25];
        dec_in.data12 = instrIn[11:0];
        dec_in.boff   = instrIn[23:0];
        dec_in.cond   = instrIn[31:28];
        dec_in.setf   = instrIn[20];
        dec_in.rn     = instrIn[19:16];
        dec_in.rd     = instrIn[15:12];
        dec_in.rm     = instrIn[3:0];
        dec_in.pc     = pcIn;
        if (instrIn[27:26] == 2'b00) begin
            dec_in.opcode = {1'b0, instrIn[24:21]};
        end else if (instrIn[27:26] == 2'b01) begin
            dec_in.opcode = 5'b10000;
        end else if (instrIn[27:25] == 3'b101) begin
            dec_in.opcode = 5'b10001;
        end else begin
            dec_in.opcode = 5'b11111;
            dec_in.undef  = 1'b1;
        end
    end

    assign in_xfer  = inValid & inReady_q;
    assign out_xfer = outValid_q & outReady;

    // Next-state and buffer data movement.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // Contents are left as-is; they are don't-care in EMPTY.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        head_d  = dec_in;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_d  = dec_in;
                    end else if (in_xfer) begin
                        skid_d  = dec_in;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // inReady is low here, so only a drain can occur.
                    if (out_xfer) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake flags are registered copies of the next state so that they
    // depend on state alone and never on same-cycle inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            inReady_q  <= (state_d != FULL);
            outValid_q <= (state_d != EMPTY);
        end
    end

    assign inReady          = inReady_q;
    assign outValid         = outValid_q;
    assign opcode           = head_q.opcode;
    assign immediateOperand = head_q.imm;
    assign data12Out        = head_q.data12;
    assign branchOffset     = head_q.boff;
    assign condCode         = head_q.cond;
    assign setFlags         = head_q.setf;
    assign rnAddr           = head_q.rn;
    assign rdAddr           = head_q.rd;
    assign rmAddr           = head_q.rm;
    assign pcOut            = head_q.pc;
    assign undefInstr       = head_q.undef;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Purpose:
//   Directed self-checking bench for decode_stage: reset state, decode of
//   each instruction class, backpressure ordering, flush and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] instrIn;
    logic [31:0] pcIn;
    logic        inValid;
    logic        inReady;
    logic        outValid;
    logic        outReady;
    logic [4:0]  opcode;
    logic        immediateOperand;
    logic [11:0] data12Out;
    logic [23:0] branchOffset;
    logic [3:0]  condCode;
    logic        setFlags;
    logic [3:0]  rnAddr;
    logic [3:0]  rdAddr;
    logic [3:0]  rmAddr;
    logic [31:0] pcOut;
    logic        undefInstr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    decode_stage dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .instrIn          (instrIn),
        .pcIn             (pcIn),
        .inValid          (inValid),
        .inReady          (inReady),
        .outValid         (outValid),
        .outReady         (outReady),
        .opcode           (opcode),
        .immediateOperand (immediateOperand),
        .data12Out        (data12Out),
        .branchOffset     (branchOffset),
        .condCode         (condCode),
        .setFlags         (setFlags),
        .rnAddr           (rnAddr),
        .rdAddr           (rdAddr),
        .rmAddr           (rmAddr),
        .pcOut            (pcOut),
        .undefInstr       (undefInstr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later and
    // inputs changed here stay stable until the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        inValid = v;
        instrIn = ins;
        pcIn    = pc;
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        outReady = 1'b0;
        drive(1'b1, 32'hE0912003, 32'h0000_0050);

        // Reset held for two edges with inValid high.
        step();
        step();
        check("rst_outValid", {31'd0, outValid}, 32'd0);
        check("rst_inReady",  {31'd0, inReady},  32'd1);
        check("rst_fieldsA",  {opcode, immediateOperand, setFlags, undefInstr, condCode, rnAddr, rdAddr, rmAddr},
                              32'd0);
        check("rst_data12",   {20'd0, data12Out},    32'd0);
        check("rst_boff",     {8'd0, branchOffset},  32'd0);
        check("rst_pcOut",    pcOut,                 32'd0);

        // Class decodes, one per cycle with outReady held high.
        reset    = 1'b1;
        outReady = 1'b1;
        drive(1'b1, 32'hE0912003, 32'h0000_0100);
        step();
        check("dp_outValid", {31'd0, outValid}, 32'd1);
        check("dp_opcode",   {27'd0, opcode},   32'h04);
        check("dp_setFlags", {31'd0, setFlags}, 32'd1);
        check("dp_regs",     {20'd0, rnAddr, rdAddr, rmAddr}, 32'h123);
        check("dp_cond",     {28'd0, condCode}, 32'hE);
        check("dp_pcOut",    pcOut,             32'h100);
        check("dp_undef",    {31'd0, undefInstr}, 32'd0);

        drive(1'b1, 32'hEAFFFFFE, 32'h0000_0104);
        step();
        check("br_opcode", {27'd0, opcode},      32'h11);
        check("br_boff",   {8'd0, branchOffset}, 32'h00FF_FFFE);
        check("br_pcOut",  pcOut,                32'h104);

        drive(1'b1, 32'hE5912004, 32'h0000_0108);
        step();
        check("ld_opcode", {27'd0, opcode},           32'h10);
        check("ld_imm",    {31'd0, immediateOperand}, 32'd0);
        check("ld_data12", {20'd0, data12Out},        32'h004);
        check("ld_regs",   {24'd0, rnAddr, rdAddr},   32'h12);

        drive(1'b1, 32'hEE000000, 32'h0000_010C);
        step();
        check("ud_opcode",   {27'd0, opcode},     32'h1F);
        check("ud_undef",    {31'd0, undefInstr}, 32'd1);
        check("ud_outValid", {31'd0, outValid},   32'd1);

        drive(1'b0, 32'h0, 32'h0);
        step();
        check("drain_outValid", {31'd0, outValid}, 32'd0);
        check("drain_inReady",  {31'd0, inReady},  32'd1);

        // Backpressure: A, B accepted, C held upstream.
        outReady = 1'b0;
        drive(1'b1, 32'hE0812003, 32'h0000_0200);
        step();
        check("bp_A_outValid", {31'd0, outValid}, 32'd1);
        check("bp_A_inReady",  {31'd0, inReady},  32'd1);
        check("bp_A_pc",       pcOut,             32'h200);
        drive(1'b1, 32'hEAFFFFFE, 32'h0000_0204);
        step();
        check("bp_B_inReady", {31'd0, inReady}, 32'd0);
        check("bp_B_pcHold",  pcOut,            32'h200);
        check("bp_B_opHold",  {27'd0, opcode},  32'h04);
        drive(1'b1, 32'hE5912004, 32'h0000_0208);
        step();
        check("bp_C_inReady", {31'd0, inReady}, 32'd0);
        check("bp_C_pcHold",  pcOut,            32'h200);
        outReady = 1'b1;
        step();
        check("bp_B_out",      pcOut,             32'h204);
        check("bp_B_opcode",   {27'd0, opcode},   32'h11);
        check("bp_B_outValid", {31'd0, outValid}, 32'd1);
        check("bp_B_inReady2", {31'd0, inReady},  32'd1);
        step();
        check("bp_C_out",      pcOut,             32'h208);
        check("bp_C_opcode",   {27'd0, opcode},   32'h10);
        check("bp_C_outValid", {31'd0, outValid}, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("bp_end_outValid", {31'd0, outValid}, 32'd0);

        // Flush a full buffer while a new instruction is offered.
        outReady = 1'b0;
        drive(1'b1, 32'hE0912003, 32'h0000_0300);
        step();
        drive(1'b1, 32'hE0912003, 32'h0000_0304);
        step();
        check("fl_full", {31'd0, inReady}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'hEAFFFFFE, 32'h0000_0308);
        step();
        check("fl_outValid", {31'd0, outValid}, 32'd0);
        check("fl_inReady",  {31'd0, inReady},  32'd1);
        flush    = 1'b0;
        outReady = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("fl_notCaptured", {31'd0, outValid}, 32'd0);

        // Reset mid-stream with a full buffer.
        outReady = 1'b0;
        drive(1'b1, 32'hE0912003, 32'h0000_0400);
        step();
        drive(1'b1, 32'hE5912004, 32'h0000_0404);
        step();
        check("mr_full", {31'd0, inReady}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("mr_outValid", {31'd0, outValid}, 32'd0);
        check("mr_inReady",  {31'd0, inReady},  32'd1);
        check("mr_pcOut",    pcOut,             32'd0);
        reset    = 1'b1;
        outReady = 1'b1;
        drive(1'b1, 32'hEAFFFFFE, 32'h0000_0500);
        step();
        check("mr_new_outValid", {31'd0, outValid},    32'd1);
        check("mr_new_pc",       pcOut,                32'h500);
        check("mr_new_opcode",   {27'd0, opcode},      32'h11);
        check("mr_new_boff",     {8'd0, branchOffset}, 32'h00FF_FFFE);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("mr_alone", {31'd0, outValid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
